mem_stage_hs: RTL and testbench

- Parametrised MEM pipeline stage for the MIPS core. Sits between EX/MEM and MEM/WB.
- Drives an external data memory through a req/ready/rvalid handshake instead of a fixed single-cycle array.
- Formats sub-word loads and stores, resolves branches into PCSrc, stalls upstream while an access is outstanding, and flags misaligned or timed-out accesses.

---
 rtl/mem_stage_hs.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: talks to data memory over req/ready/rvalid, formats
// sub-word loads and stores, resolves branches and raises misalign/bus faults.
module mem_stage_hs #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [DATA_W-1:0]     Rt,
  input  logic [REG_ADDR_W-1:0] AddressSelected,
  input  logic                  Zero,
  input  logic                  SignBit,
  input  logic                  Branch,
  input  logic [2:0]            BranchLogicOp,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemToReg,
  input  logic                  RegWrite,
  input  logic [1:0]            BitSel,
  input  logic                  LoadUnsigned,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic                  Stall,
  output logic                  PCSrc,
  output logic                  Valid_out,
  output logic                  RegWrite_out,
  output logic                  MemToReg_out,
  output logic [DATA_W-1:0]     MemoryRead_out,
  output logic [DATA_W-1:0]     ALUResult_out,
  output logic [REG_ADDR_W-1:0] AddressSelected_out,
  output logic                  MisalignFault_out,
  output logic                  BusFault_out,
  output logic                  dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    regwrite_q, regwrite_d;
  logic                    memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0]       memread_q, memread_d;
  logic [DATA_W-1:0]       alu_q, alu_d;
  logic [REG_ADDR_W-1:0]   addrsel_q, addrsel_d;
  logic                    misf_q, misf_d;
  logic                    busf_q, busf_d;

  logic [OFF_W-1:0]        off;
  logic                    misalign;
  logic                    br_cond;
  logic [NB-1:0]           be;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       rd_shift;
  logic [DATA_W-1:0]       rd_fmt;
  logic                    is_mem;
  logic                    to_hit;
  logic                    retire;
  logic                    mis_f;
  logic                    bus_f;
  logic                    rd_sel;
  logic                    req;
  logic                    stall;

  assign off = ALUResult[OFF_W-1:0];

  always_comb begin
    case (BitSel)
      2'b00:   misalign = (off != '0);
      2'b01:   misalign = off[0];
      2'b10:   misalign = 1'b0;
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    case (BranchLogicOp)
      3'b000:  br_cond = Zero;
      3'b001:  br_cond = !Zero;
      3'b010:  br_cond = !SignBit && !Zero;
      3'b011:  br_cond = SignBit || Zero;
      3'b100:  br_cond = AddressSelected[0] ? !SignBit : SignBit;
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrc = in_valid & Branch & br_cond;

  // Store data is replicated across every lane so memory only needs mem_be.
  always_comb begin
    case (BitSel)
      2'b10: begin
        be    = NB'(1) << off;
        wdata = {NB{Rt[7:0]}};
      end
      2'b01: begin
        be    = NB'(3) << off;
        wdata = {(NB/2){Rt[15:0]}};
      end
      default: begin
        be    = '1;
        wdata = Rt;
      end
    endcase
  end

  assign rd_shift = mem_rdata >> {off, 3'b000};

  always_comb begin
    case (BitSel)
      2'b10:   rd_fmt = LoadUnsigned ? DATA_W'(rd_shift[7:0])
                                     : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_fmt = LoadUnsigned ? DATA_W'(rd_shift[15:0])
                                     : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = mem_rdata;
    endcase
  end

  assign is_mem = in_valid & (MemRead | MemWrite);
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Handshake: mem_req stays high with addr/we/be/wdata stable until a cycle
  // with mem_req & mem_ready (accept). A read's mem_rvalid is taken only in
  // S_WAIT, so it never counts in the accept cycle itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    mis_f   = 1'b0;
    bus_f   = 1'b0;
    rd_sel  = 1'b0;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          retire = 1'b1;
        end else if (misalign) begin
          retire = 1'b1;
          mis_f  = 1'b1;
        end else begin
          req = 1'b1;
          if (mem_ready) begin
            cnt_d = '0;
            if (MemWrite) begin
              retire = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = S_WAIT;
            end
          end else if (to_hit) begin
            retire = 1'b1;
            bus_f  = 1'b1;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          retire  = 1'b1;
          rd_sel  = 1'b1;
          state_d = S_IDLE;
        end else if (to_hit) begin
          retire  = 1'b1;
          bus_f   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (retire) cnt_d = '0;
  end

  // Non-retire cycles send a bubble to WB while data fields keep their value.
  always_comb begin
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    misf_d     = 1'b0;
    busf_d     = 1'b0;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    alu_d      = alu_q;
    addrsel_d  = addrsel_q;
    if (retire) begin
      valid_d    = in_valid;
      regwrite_d = in_valid & RegWrite & ~mis_f & ~bus_f;
      misf_d     = mis_f;
      busf_d     = bus_f;
      memtoreg_d = MemToReg;
      memread_d  = rd_sel ? rd_fmt : '0;
      alu_d      = ALUResult;
      addrsel_d  = AddressSelected;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= '0;
      alu_q      <= '0;
      addrsel_q  <= '0;
      misf_q     <= 1'b0;
      busf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      alu_q      <= alu_d;
      addrsel_q  <= addrsel_d;
      misf_q     <= misf_d;
      busf_q     <= busf_d;
    end
  end

  assign mem_req   = req;
  assign mem_we    = req & MemWrite;
  assign mem_addr  = {ALUResult[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = wdata;
  assign mem_be    = be;
  assign Stall     = stall;

  assign Valid_out           = valid_q;
  assign RegWrite_out        = regwrite_q;
  assign MemToReg_out        = memtoreg_q;
  assign MemoryRead_out      = memread_q;
  assign ALUResult_out       = alu_q;
  assign AddressSelected_out = addrsel_q;
  assign MisalignFault_out   = misf_q;
  assign BusFault_out        = busf_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: vector table with a reactive memory model, a retire
// scoreboard, and hand-written reset-during-wait sequence.
module tb_mem_stage_hs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TIMEOUT    = 15;
  localparam int SB_W       = 2*DATA_W + REG_ADDR_W + 4;
  localparam int NEVER      = 1000;

  logic                  Clk;
  logic                  Rst_n;
  logic                  in_valid;
  logic [DATA_W-1:0]     ALUResult;
  logic [DATA_W-1:0]     Rt;
  logic [REG_ADDR_W-1:0] AddressSelected;
  logic                  Zero, SignBit, Branch;
  logic [2:0]            BranchLogicOp;
  logic                  MemRead, MemWrite, MemToReg, RegWrite;
  logic [1:0]            BitSel;
  logic                  LoadUnsigned;
  logic                  mem_ready, mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_req, mem_we;
  logic [DATA_W-1:0]     mem_addr, mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  Stall, PCSrc;
  logic                  Valid_out, RegWrite_out, MemToReg_out;
  logic [DATA_W-1:0]     MemoryRead_out, ALUResult_out;
  logic [REG_ADDR_W-1:0] AddressSelected_out;
  logic                  MisalignFault_out, BusFault_out;
  logic                  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rt;
    logic [REG_ADDR_W-1:0] rsel;
    logic                  rd, wr, rw, m2r, lu;
    logic [1:0]            bs;
    logic                  br, zero, sign;
    logic [2:0]            bop;
    int                    ready_lat;
    int                    rvalid_lat;
    logic [DATA_W-1:0]     rdata;
    logic                  pcsrc;
    int                    req_cyc;
    int                    stall_cyc;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     mrd;
    logic                  rw_out, misf, busf;
  } vec_t;

  vec_t vecs[$];

  mem_stage_hs #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .ALUResult(ALUResult), .Rt(Rt),
    .AddressSelected(AddressSelected), .Zero(Zero), .SignBit(SignBit), .Branch(Branch),
    .BranchLogicOp(BranchLogicOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .BitSel(BitSel), .LoadUnsigned(LoadUnsigned),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .Stall(Stall), .PCSrc(PCSrc), .Valid_out(Valid_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .MemoryRead_out(MemoryRead_out), .ALUResult_out(ALUResult_out),
    .AddressSelected_out(AddressSelected_out), .MisalignFault_out(MisalignFault_out),
    .BusFault_out(BusFault_out), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    Clk   = 1'b0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
  end
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic set_idle();
    in_valid = 0; ALUResult = '0; Rt = '0; AddressSelected = '0;
    Zero = 0; SignBit = 0; Branch = 0; BranchLogicOp = '0;
    MemRead = 0; MemWrite = 0; MemToReg = 0; RegWrite = 0;
    BitSel = '0; LoadUnsigned = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Scoreboard: every retire with Valid_out high consumes one expected record.
  always @(negedge Clk) begin
    if (Valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 1, 0);
      end else begin
        logic [SB_W-1:0] exp_rec;
        exp_rec = exp_q.pop_front();
        check("retire", {ALUResult_out, MemoryRead_out, AddressSelected_out,
                         RegWrite_out, MemToReg_out, MisalignFault_out, BusFault_out},
              exp_rec);
      end
    end
  end

  function automatic vec_t nv(input logic [DATA_W-1:0] alu);
    vec_t v;
    v = '{default: 0};
    v.alu = alu;
    v.ready_lat = NEVER;
    v.rvalid_lat = NEVER;
    return v;
  endfunction

  function automatic vec_t br_vec(input logic [DATA_W-1:0] alu, input logic b,
                                  input logic [2:0] op, input logic z, input logic s,
                                  input logic [REG_ADDR_W-1:0] rsel, input logic exp_pc);
    vec_t v;
    v = nv(alu);
    v.br = b; v.bop = op; v.zero = z; v.sign = s; v.rsel = rsel; v.pcsrc = exp_pc;
    return v;
  endfunction

  // Driver plus reactive memory: mem_ready is offered at cycle ready_lat until an
  // accept, mem_rvalid fires rvalid_lat cycles after the accept cycle.
  task automatic drive_vec(input int idx, input vec_t v);
    int cyc, acc_cyc, req_cnt, stall_cnt;
    bit done, acc_now, seen_req;
    in_valid = 1; ALUResult = v.alu; Rt = v.rt; AddressSelected = v.rsel;
    Zero = v.zero; SignBit = v.sign; Branch = v.br; BranchLogicOp = v.bop;
    MemRead = v.rd; MemWrite = v.wr; MemToReg = v.m2r; RegWrite = v.rw;
    BitSel = v.bs; LoadUnsigned = v.lu;
    exp_q.push_back({v.alu, v.mrd, v.rsel, v.rw_out, v.m2r, v.misf, v.busf});
    cyc = 0; acc_cyc = -1; req_cnt = 0; stall_cnt = 0; done = 0; seen_req = 0;
    while (!done && cyc < 64) begin
      mem_ready  = (acc_cyc < 0) && (cyc == v.ready_lat);
      mem_rvalid = (acc_cyc >= 0) && (cyc == acc_cyc + v.rvalid_lat);
      mem_rdata  = mem_rvalid ? v.rdata : DATA_W'($urandom);
      @(negedge Clk);
      if (cyc == 0) check($sformatf("v%0d_pcsrc", idx), PCSrc, v.pcsrc);
      acc_now = mem_req && mem_ready;
      if (mem_req) begin
        req_cnt++;
        if (!seen_req) begin
          seen_req = 1;
          check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
          check($sformatf("v%0d_we", idx), mem_we, v.wr);
          if (v.wr) begin
            check($sformatf("v%0d_be", idx), mem_be, v.be);
            check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
          end
        end
      end
      if (Stall) stall_cnt++;
      else done = 1;
      @(posedge Clk); #1;
      if (acc_now && acc_cyc < 0) acc_cyc = cyc;
      cyc++;
    end
    if (!done) check($sformatf("v%0d_stall_bound", idx), 0, 1);
    check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.stall_cyc);
    check($sformatf("v%0d_req_cycles", idx), req_cnt, v.req_cyc);
    set_idle();
    @(negedge Clk);
    @(posedge Clk); #1;
    @(negedge Clk);
    check($sformatf("v%0d_bubble", idx), {Valid_out, MisalignFault_out, BusFault_out}, 3'b000);
    @(posedge Clk); #1;
  endtask

  initial begin
    vec_t v;
    set_idle();

    // ALU op: no memory traffic
    v = nv(32'h1234); v.rw = 1; v.rsel = 5'd7; v.rw_out = 1; vecs.push_back(v);
    // Signed / unsigned byte load at offset 3
    v = nv(32'h203); v.rd = 1; v.rw = 1; v.m2r = 1; v.bs = 2'b10; v.rsel = 5'd9;
    v.ready_lat = 0; v.rvalid_lat = 2; v.rdata = 32'h8000_0000;
    v.req_cyc = 1; v.stall_cyc = 2; v.addr = 32'h200; v.mrd = 32'hFFFF_FF80; v.rw_out = 1;
    vecs.push_back(v);
    v.lu = 1; v.mrd = 32'h0000_0080; vecs.push_back(v);
    // Half store at offset 2
    v = nv(32'h102); v.wr = 1; v.bs = 2'b01; v.rt = 32'h1234_ABCD; v.ready_lat = 0;
    v.req_cyc = 1; v.be = 4'b1100; v.wdata = 32'hABCD_ABCD; v.addr = 32'h100;
    vecs.push_back(v);
    // Misaligned word load
    v = nv(32'h101); v.rd = 1; v.rw = 1; v.rsel = 5'd4; v.misf = 1; vecs.push_back(v);
    // Bus timeout waiting for mem_ready
    v = nv(32'h40); v.rd = 1; v.rw = 1; v.m2r = 1; v.rsel = 5'd5;
    v.req_cyc = TIMEOUT; v.stall_cyc = TIMEOUT - 1; v.addr = 32'h40; v.busf = 1;
    vecs.push_back(v);
    // mem_rvalid arrives in the timeout cycle of WAIT_RESP
    v = nv(32'h44); v.rd = 1; v.rw = 1; v.m2r = 1; v.rsel = 5'd6;
    v.ready_lat = 0; v.rvalid_lat = TIMEOUT; v.rdata = 32'hDEAD_BEEF;
    v.req_cyc = 1; v.stall_cyc = TIMEOUT; v.addr = 32'h44; v.mrd = 32'hDEAD_BEEF; v.rw_out = 1;
    vecs.push_back(v);
    // Byte store at offset 1 with a delayed ready
    v = nv(32'h301); v.wr = 1; v.bs = 2'b10; v.rt = 32'h1234_565A; v.ready_lat = 2;
    v.req_cyc = 3; v.stall_cyc = 2; v.be = 4'b0010; v.wdata = 32'h5A5A_5A5A; v.addr = 32'h300;
    vecs.push_back(v);
    // Signed half load at offset 2, minimum rvalid latency after a late accept
    v = nv(32'h12); v.rd = 1; v.rw = 1; v.bs = 2'b01; v.rsel = 5'd8;
    v.ready_lat = 1; v.rvalid_lat = 1; v.rdata = 32'h8001_7FFF;
    v.req_cyc = 2; v.stall_cyc = 2; v.addr = 32'h10; v.mrd = 32'hFFFF_8001; v.rw_out = 1;
    vecs.push_back(v);
    // Word store accepted exactly in the timeout cycle
    v = nv(32'h20); v.wr = 1; v.rt = 32'hCAFE_F00D; v.ready_lat = TIMEOUT - 1;
    v.req_cyc = TIMEOUT; v.stall_cyc = TIMEOUT - 1; v.be = 4'b1111; v.wdata = 32'hCAFE_F00D;
    v.addr = 32'h20; vecs.push_back(v);
    // Misaligned half store, illegal size
    v = nv(32'h33); v.wr = 1; v.bs = 2'b01; v.misf = 1; vecs.push_back(v);
    v = nv(32'h0); v.rd = 1; v.rw = 1; v.bs = 2'b11; v.misf = 1; vecs.push_back(v);
    // Branch conditions
    vecs.push_back(br_vec(32'h1000, 1, 3'b100, 0, 0, 5'd1, 1));
    vecs.push_back(br_vec(32'h1004, 1, 3'b100, 0, 0, 5'd2, 0));
    vecs.push_back(br_vec(32'h1008, 1, 3'b100, 0, 1, 5'd2, 1));
    vecs.push_back(br_vec(32'h100C, 1, 3'b000, 1, 0, 5'd0, 1));
    vecs.push_back(br_vec(32'h1010, 1, 3'b001, 1, 0, 5'd0, 0));
    vecs.push_back(br_vec(32'h1014, 1, 3'b010, 0, 0, 5'd0, 1));
    vecs.push_back(br_vec(32'h1018, 1, 3'b011, 0, 0, 5'd0, 0));
    vecs.push_back(br_vec(32'h101C, 1, 3'b111, 1, 1, 5'd0, 0));
    vecs.push_back(br_vec(32'h1020, 0, 3'b000, 1, 0, 5'd0, 0));

    #11;
    check("reset_regs", {Valid_out, RegWrite_out, MemToReg_out, MisalignFault_out,
                         BusFault_out, MemoryRead_out, ALUResult_out, AddressSelected_out}, '0);
    check("reset_comb", {Stall, mem_req}, 2'b00);
    @(negedge Clk); Rst_n = 1;
    @(posedge Clk); #1;

    foreach (vecs[i]) drive_vec(i, vecs[i]);

    // Reset while a load waits in WAIT_RESP; a late rvalid must be ignored.
    in_valid = 1; ALUResult = 32'h80; MemRead = 1; RegWrite = 1; MemToReg = 1;
    AddressSelected = 5'd3; mem_ready = 1;
    @(negedge Clk);
    check("rst_seq_req", mem_req, 1);
    @(posedge Clk); #1;
    mem_ready = 0;
    @(negedge Clk);
    check("rst_seq_wait", {Stall, dbg_state}, 2'b11);
    Rst_n = 0;
    set_idle();
    #1;
    check("rst_seq_regs", {Valid_out, RegWrite_out, MemToReg_out, MisalignFault_out,
                           BusFault_out, MemoryRead_out, ALUResult_out, AddressSelected_out}, '0);
    check("rst_seq_comb", {Stall, mem_req, dbg_state}, 3'b000);
    @(posedge Clk);
    @(negedge Clk); Rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge Clk);
      check($sformatf("late_rvalid_%0d", k), {Valid_out, MemoryRead_out}, '0);
    end
    set_idle();
    @(posedge Clk); #1;

    drive_vec(99, vecs[0]);

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
